// File: rtl/demux14_reg_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
package demux_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux14_reg_if.sv
// Producer-side handshake plus the four consumer channels of demux14_reg.
interface demux14_reg_if
    import demux_pkg::*;
#(
    parameter int Size = 8
);
    logic [Size-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    sel_t             s;
    logic             rr_en;
    logic [Size-1:0]  y0;
    logic [Size-1:0]  y1;
    logic [Size-1:0]  y2;
    logic [Size-1:0]  y3;
    logic [N_CH-1:0]  y_valid;
    logic [N_CH-1:0]  y_ready;
    sel_t             rr_ptr;

    modport master (
        output in_data, in_valid, s, rr_en, y_ready,
        input  in_ready, y0, y1, y2, y3, y_valid, rr_ptr
    );

    modport slave (
        input  in_data, in_valid, s, rr_en, y_ready,
        output in_ready, y0, y1, y2, y3, y_valid, rr_ptr
    );
endinterface

// File: rtl/demux14_reg_slot.sv
// One-entry channel register: loads on accept, clears valid on consumer handshake.
module demux_slot #(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [Size-1:0] data,
    input  logic            ready,
    output logic [Size-1:0] q,
    output logic            valid
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            // a reload wins over a same-cycle drain so valid stays high
            q     <= data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux14_reg.sv
// Registered 1-to-4 demux: select logic, round-robin pointer and in_ready mux
// in front of four independent channel registers.
module demux14_reg
    import demux_pkg::*;
#(
    parameter int Size = 8
) (
    input logic         clk,
    input logic         rst_n,
    demux14_reg_if.slave bus
);
    sel_t            sel;
    sel_t            rr_ptr_q;
    logic            accept;
    logic [N_CH-1:0] load;
    logic [N_CH-1:0] valid;
    logic [Size-1:0] q [N_CH];

    always_comb begin
        sel          = bus.rr_en ? rr_ptr_q : bus.s;
        // strict round-robin: a stalled target holds in_ready low, never skipped
        bus.in_ready = rst_n & (~valid[sel] | bus.y_ready[sel]);
        accept       = bus.in_valid & bus.in_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (accept && bus.rr_en) begin
            rr_ptr_q <= rr_ptr_q + sel_t'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        assign load[i] = accept & (sel == sel_t'(i));

        demux_slot #(.Size(Size)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .data  (bus.in_data),
            .ready (bus.y_ready[i]),
            .q     (q[i]),
            .valid (valid[i])
        );
    end

    assign bus.y0      = q[0];
    assign bus.y1      = q[1];
    assign bus.y2      = q[2];
    assign bus.y3      = q[3];
    assign bus.y_valid = valid;
    assign bus.rr_ptr  = rr_ptr_q;
endmodule

// File: doc/demux14_reg.md
Name: demux14_reg

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the 4x1 mux; routes one Size-bit input stream to one of four output channels.
- Input side uses a valid/ready handshake; each output channel holds a one-entry register with its own valid/ready pair.
- Two select modes: explicit select `s`, or an internal round-robin pointer.
- Sits between a single producer and up to four consumer datapaths in the same design.

Parameters:
- Size, 8, data width of input and of each output channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  Size  input word.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept in_data this cycle.
- s  input  2  explicit channel select (0..3); used when rr_en=0.
- rr_en  input  1  1 = round-robin mode using rr_ptr; 0 = explicit select `s`.
- y0, y1, y2, y3  output  Size each  channel data registers.
- y_valid  output  4  bit i = channel i holds a word.
- y_ready  input  4  bit i = consumer i accepts the word this cycle.
- rr_ptr  output  2  current round-robin channel.

Behaviour:
- Reset (rst_n=0 at a clk edge): y0..y3 <= 0, y_valid <= 4'b0000, rr_ptr <= 0. While rst_n=0, in_ready=0.
- Effective select is combinational: sel = rr_en ? rr_ptr : s.
- in_ready = rst_n & (~y_valid[sel] | y_ready[sel]). This is combinational and may depend on y_ready; same-cycle drain-and-refill is allowed.
- Accept occurs when in_valid & in_ready. At that edge:
  - y[sel] <= in_data.
  - y_valid[sel] <= 1.
  - Latency is 1 cycle: the word is visible on y[sel] in the cycle after accept.
- Drain: when y_valid[i] & y_ready[i], y_valid[i] <= 0 at the edge, unless channel i is reloaded by an accept in the same cycle; then it stays 1 with the new data.
- Stall: while y_valid[i]=1 and y_ready[i]=0, y[i] and y_valid[i] hold stable. The consumer must see no data change without a handshake.
- Channels are independent:
  - A full, stalled channel blocks in_ready only when that channel is selected.
  - Other channels keep draining.
  - Accepts to other channels proceed.
- y[i] keeps its last value after it drains; no zeroing except on reset.
- rr_ptr:
  - Increments modulo 4 on each accept when rr_en=1, wrapping 3 -> 0.
  - Holds when rr_en=0 or when no accept occurs.
  - A stalled target channel is never skipped: round-robin is strict, so in_ready stays 0 until that channel frees.
- rr_en and s may change in any cycle. They are sampled only at the accept edge, and changing them redirects in_ready immediately (combinational).
- in_valid=1 with in_ready=0: no state change. The producer must hold in_data.
- Reset mid-operation: all pending channel words are discarded, y_valid clears, rr_ptr returns to 0, and no partial transfer occurs.
- y_ready[i] asserted while y_valid[i]=0 is ignored.

Decomposition:
- Shared package demux_pkg:
  - N_CH = 4.
  - SEL_W = 2.
  - typedef sel_t as logic [SEL_W-1:0].
- Natural sub-module demux_slot #(Size): a one-entry channel register with load/drain handshake, instantiated four times.
- Top level holds the select logic, rr_ptr, and the in_ready mux.

Test Plan:
1. Reset then explicit routing: rst_n=0 for 2 cycles, then rr_en=0, y_ready=4'b1111; send 8'hA0, A1, A2, A3 with s=0,1,2,3 -> each appears on y0..y3 one cycle after accept; y_valid pulses one cycle per channel; in_ready stays 1.
2. Backpressure: y_ready[2]=0; send 8'h55 with s=2, then 8'h66 with s=2 -> y2=8'h55 held, in_ready=0 on the second word; raise y_ready[2] -> 8'h66 is loaded in the same cycle as 8'h55 drains; y_valid[2] stays 1.
3. Independent channels: with channel 1 stalled full, send s=3 data 8'h3C -> accepted, y3=8'h3C next cycle; y1 is unchanged.
4. Round-robin wrap: rr_en=1, y_ready=4'b1111, send 6 words 8'h10..8'h15 -> routed to ch 0,1,2,3,0,1; rr_ptr sequence 0,1,2,3,0,1,2.
5. Round-robin stall: rr_en=1, rr_ptr=1, channel 1 full with y_ready[1]=0 -> in_ready=0 and rr_ptr holds at 1; release y_ready[1] -> the pending word is accepted into ch1 and rr_ptr becomes 2.
6. Reset mid-operation: with channels 0 and 2 full and stalled, pulse rst_n=0 for one cycle -> y_valid=4'b0000, y0..y3=0, rr_ptr=0 the next cycle; in_ready=1 once rst_n=1.
